// File: rtl/alu_exec_pkg.sv
// Shared op-code and state encodings for the execute/write-back sequencer.
// Used by alu_exec_seq (optional multiplier selected with ALU_EXEC_MUL_EN).
package alu_exec_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

endpackage

// File: rtl/mul_shift_add_32.sv
// Radix-2 shift-add multiplier: low 32 bits of an unsigned 32x32 product.
// The go edge performs the first of 32 iterations; busy falls after the last.
module mul_shift_add_32 (
  input  logic        clk,
  input  logic        cr,
  input  logic        go,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] p
);

  logic [4:0]  r_cnt;
  logic [31:0] r_acc;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_busy;

  always_ff @(posedge clk) begin
    if (cr) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_busy <= 1'b0;
    end else if (go) begin
      r_acc  <= b[0] ? a : '0;
      r_a    <= a << 1;
      r_b    <= b >> 1;
      r_cnt  <= 5'd1;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_b[0]) r_acc <= r_acc + r_a;
      r_a   <= r_a << 1;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt + 5'd1;
      if (r_cnt == 5'd31) r_busy <= 1'b0;
    end
  end

  assign busy = r_busy;
  assign p    = r_acc;

endmodule

// File: rtl/alu_exec_seq.sv
// Execute/write-back sequencer between the 8x32 register file read and write ports.
// Define ALU_EXEC_MUL_EN to build the 32-cycle multiplier for op 111.
module alu_exec_seq
  import alu_exec_pkg::*;
(
  input  logic              clk,
  input  logic              cr,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic [ADDR_W-1:0] rw,
  input  logic [DATA_W-1:0] QA,
  input  logic [DATA_W-1:0] QB,
  output logic [ADDR_W-1:0] Addr_A,
  output logic [ADDR_W-1:0] Addr_B,
  output logic [ADDR_W-1:0] Addr_W,
  output logic [DATA_W-1:0] Di,
  output logic              WE,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic              zero
);

  state_t              r_state;
  logic [2:0]          r_op;
  logic [DATA_W-1:0]   r_op_a, r_op_b, r_di;
  logic [ADDR_W-1:0]   r_addr_a, r_addr_b, r_addr_w;
  logic                r_we, r_done, r_busy, r_illegal, r_zero;
  logic [DATA_W-1:0]   w_alu, w_result;
  logic                w_exec_done, w_illegal;

  // NOTE: every output of always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_alu = '0;
    case (r_op)
      OP_ADD:  w_alu = r_op_a + r_op_b;
      OP_SUB:  w_alu = r_op_a - r_op_b;
      OP_AND:  w_alu = r_op_a & r_op_b;
      OP_OR:   w_alu = r_op_a | r_op_b;
      OP_XOR:  w_alu = r_op_a ^ r_op_b;
      OP_SLT:  w_alu = {31'd0, $signed(r_op_a) < $signed(r_op_b)};
      OP_SRL:  w_alu = r_op_a >> r_op_b[4:0];
      default: w_alu = '0;
    endcase
  end

`ifdef ALU_EXEC_MUL_EN
  logic              w_mul_busy;
  logic [DATA_W-1:0] w_mul_p;

  // Operands go straight from QA/QB so the first iteration overlaps operand capture.
  mul_shift_add_32 u_mul (
    .clk  (clk),
    .cr   (cr),
    .go   ((r_state == S_READ) && (r_op == OP_MUL)),
    .a    (QA),
    .b    (QB),
    .busy (w_mul_busy),
    .p    (w_mul_p)
  );

  assign w_exec_done = (r_op != OP_MUL) || !w_mul_busy;
  assign w_illegal   = 1'b0;
  assign w_result    = (r_op == OP_MUL) ? w_mul_p : w_alu;
`else
  assign w_exec_done = 1'b1;
  assign w_illegal   = (r_op == OP_MUL);
  assign w_result    = w_alu;
`endif

  // NOTE: operand registers are pure datapath and are always loaded before use, so no reset.
  always_ff @(posedge clk) begin
    if (r_state == S_READ) begin
      r_op_a <= QA;
      r_op_b <= QB;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (cr) begin
      r_state   <= S_IDLE;
      r_op      <= OP_ADD;
      r_addr_a  <= '0;
      r_addr_b  <= '0;
      r_addr_w  <= '0;
      r_di      <= '0;
      r_we      <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_illegal <= 1'b0;
      r_zero    <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_op      <= op;
          r_addr_a  <= ra;
          r_addr_b  <= rb;
          r_addr_w  <= rw;
          r_busy    <= 1'b1;
          r_illegal <= 1'b0;
          r_state   <= S_READ;
        end
        S_READ: r_state <= S_EXEC;
        S_EXEC: if (w_exec_done) begin
          r_di      <= w_result;
          r_zero    <= (w_result == '0);
          r_illegal <= w_illegal;
          r_we      <= !w_illegal;
          r_done    <= 1'b1;
          r_state   <= S_WB;
        end
        S_WB: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Reset asserted during WB must suppress the commit at that very edge.
  assign WE      = r_we & ~cr;
  assign done    = r_done & ~cr;
  assign busy    = r_busy;
  assign illegal = r_illegal;
  assign zero    = r_zero;
  assign Di      = r_di;
  assign Addr_A  = r_addr_a;
  assign Addr_B  = r_addr_b;
  assign Addr_W  = r_addr_w;

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed bench for alu_exec_seq with a behavioural 8x32 register file.
// Honours ALU_EXEC_MUL_EN for the op-111 expectations.
module tb_alu_exec_seq;
  import alu_exec_pkg::*;

  logic        clk = 1'b0;
  logic        cr, start;
  logic [2:0]  op, ra, rb, rw;
  logic [31:0] QA, QB;
  logic [2:0]  Addr_A, Addr_B, Addr_W;
  logic [31:0] Di;
  logic        WE, busy, done, illegal, zero;

  logic [31:0] rf [8];
  logic        tb_wr;
  logic [2:0]  tb_wa;
  logic [31:0] tb_wd;
  int          we_cnt = 0, done_cnt = 0;
  int          n_chk = 0, n_pass = 0;

  alu_exec_seq dut (
    .clk(clk), .cr(cr), .start(start), .op(op), .ra(ra), .rb(rb), .rw(rw),
    .QA(QA), .QB(QB), .Addr_A(Addr_A), .Addr_B(Addr_B), .Addr_W(Addr_W),
    .Di(Di), .WE(WE), .busy(busy), .done(done), .illegal(illegal), .zero(zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (WE) rf[Addr_W] <= Di;
    else if (tb_wr) rf[tb_wa] <= tb_wd;
  end
  assign QA = rf[Addr_A];
  assign QB = rf[Addr_B];

  always @(posedge clk) begin
    if (WE) we_cnt++;
    if (done) done_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic load(input logic [2:0] a, input logic [31:0] d);
    tb_wr = 1'b1; tb_wa = a; tb_wd = d;
    tick;
    tb_wr = 1'b0;
  endtask

  // Accepts one request and returns in the WB cycle (or after a 60-cycle budget).
  task automatic issue(input logic [2:0] o, a, b, w, output int lat, output int bcnt);
    start = 1'b1; op = o; ra = a; rb = b; rw = w;
    tick;
    start = 1'b0;
    lat = 1;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 60) begin
      tick;
      lat++;
      if (busy) bcnt++;
    end
  endtask

  task automatic run_alu(input string tag, input logic [2:0] o, a, b, w,
                         input logic [31:0] exp_di, input logic exp_zero);
    int lat, bcnt;
    issue(o, a, b, w, lat, bcnt);
    check({tag, "_lat"}, lat, 3);
    check({tag, "_busy_cycles"}, bcnt, 3);
    check({tag, "_we"}, WE, 1);
    check({tag, "_addr_w"}, Addr_W, w);
    check({tag, "_di"}, Di, exp_di);
    check({tag, "_zero"}, zero, exp_zero);
    tick;
    check({tag, "_rf"}, rf[w], exp_di);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int lat, bcnt, w0, d0, t1, t2;
    cr = 1'b1; start = 1'b0; op = '0; ra = '0; rb = '0; rw = '0;
    tb_wr = 1'b0; tb_wa = '0; tb_wd = '0;
    tick; tick;
    check("rst_outs", {WE, done, busy, illegal, zero}, 5'b0);
    check("rst_di", Di, 0);
    check("rst_addr", {Addr_A, Addr_B, Addr_W}, 9'b0);
    cr = 1'b0;
    tick;

    load(1, 32'd5); load(2, 32'd7);
    run_alu("add", OP_ADD, 1, 2, 3, 32'd12, 1'b0);
    load(4, 32'd3); load(5, 32'd3);
    run_alu("sub_alias", OP_SUB, 4, 5, 4, 32'd0, 1'b1);

    load(1, 32'hFFFF_FFFF); load(2, 32'd1);
    run_alu("slt", OP_SLT, 1, 2, 6, 32'd1, 1'b0);
    run_alu("slt_rev", OP_SLT, 2, 1, 6, 32'd0, 1'b1);
    load(2, 32'd4);
    run_alu("srl", OP_SRL, 1, 2, 7, 32'h0FFF_FFFF, 1'b0);
    run_alu("and", OP_AND, 1, 2, 7, 32'h0000_0004, 1'b0);
    run_alu("or",  OP_OR,  1, 2, 7, 32'hFFFF_FFFF, 1'b0);
    run_alu("xor", OP_XOR, 1, 2, 7, 32'hFFFF_FFFB, 1'b0);
    run_alu("add_wrap", OP_ADD, 1, 2, 7, 32'h0000_0003, 1'b0);

    load(0, 32'hA5); load(1, 32'h0001_0000); load(2, 32'h0001_0003);
    issue(OP_MUL, 1, 2, 0, lat, bcnt);
`ifdef ALU_EXEC_MUL_EN
    check("mul_lat", lat, 34);
    check("mul_we", WE, 1);
    check("mul_di", Di, 32'h0003_0000);
    check("mul_illegal", illegal, 0);
    check("mul_zero", zero, 0);
    tick;
    check("mul_rf", rf[0], 32'h0003_0000);
`else
    check("mul_lat", lat, 3);
    check("mul_we", WE, 0);
    check("mul_done", done, 1);
    check("mul_illegal", illegal, 1);
    check("mul_di", Di, 0);
    check("mul_zero", zero, 1);
    tick;
    check("mul_rf", rf[0], 32'hA5);
    check("mul_illegal_held", illegal, 1);
`endif

    load(1, 32'd10); load(2, 32'd20); load(6, 32'hDEAD);
    w0 = we_cnt; d0 = done_cnt;
    start = 1'b1; op = OP_ADD; ra = 1; rb = 2; rw = 5;
    tick;
    start = 1'b0;
    check("illegal_clr", illegal, 0);
    tick;
    start = 1'b1; op = OP_SUB; ra = 1; rb = 2; rw = 6;
    tick;
    start = 1'b0;
    check("ign_done", done, 1);
    check("ign_di", Di, 32'd30);
    tick; tick; tick;
    check("ign_we_pulses", we_cnt - w0, 1);
    check("ign_done_pulses", done_cnt - d0, 1);
    check("ign_rf5", rf[5], 32'd30);
    check("ign_rf6", rf[6], 32'hDEAD);

    t1 = -1; t2 = -1;
    start = 1'b1; op = OP_ADD; ra = 1; rb = 2; rw = 3;
    for (int c = 1; c <= 30 && t2 < 0; c++) begin
      tick;
      if (done) begin
        if (t1 < 0) t1 = c;
        else begin
          t2 = c;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b_period", t2 - t1, 4);
    tick;
    check("b2b_idle", busy, 0);

    load(1, 32'd9); load(2, 32'd9); load(3, 32'h1234);
    issue(OP_SUB, 1, 2, 3, lat, bcnt);
    check("rstwb_in_wb", {done, zero}, 2'b11);
    cr = 1'b1;
    tick;
    cr = 1'b0;
    check("rstwb_rf", rf[3], 32'h1234);
    check("rstwb_outs", {WE, done, busy, illegal, zero}, 5'b0);
    check("rstwb_di", Di, 0);
    check("rstwb_addr", {Addr_A, Addr_B, Addr_W}, 9'b0);
    run_alu("post_rst", OP_ADD, 1, 2, 3, 32'd18, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_exec_seq.md
# alu_exec_seq

Multi-cycle execute/write-back sequencer directly downstream of the 8×32 register file. On a start request it:
- drives the two register-file read addresses;
- captures the operands returned on QA/QB;
- executes one ALU operation;
- writes the result back through the register file's write port (Di, Addr_W, WE), with a start/busy/done handshake to the controller.

It is the datapath consumer of the register file's read ports and the sole producer on its write port.

## Interface
Parameters:
- none; width fixed at 32 data bits, 3 address bits.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- cr  in  1  reset: synchronous and active-high
- start  in  1  request; sampled only in IDLE
- op  in  3  operation code, captured with start
- ra, rb, rw  in  3 each  source A, source B and destination register indices, captured with start
- QA, QB  in  32 each  register-file read data, combinational from Addr_A/Addr_B
- Addr_A, Addr_B  out  3 each  register-file read addresses (registered)
- Addr_W  out  3  register-file write address (registered)
- Di  out  32  write-back data (registered)
- WE  out  1  register-file write enable, one-cycle pulse
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, coincident with WE cycle
- illegal  out  1  registered; set at done when op unsupported, cleared on next accepted start
- zero  out  1  registered; result==0, updated at each done, held otherwise

## Operation
State machine transitions:
- IDLE -> READ when start=1.
  - On this edge, latch op and rw.
  - Drive Addr_A<=ra and Addr_B<=rb; Addr_W<=rw.
- READ -> EXEC unconditionally. Capture opA<=QA, opB<=QB.
- EXEC -> WB after the operation completes.
  - Single-cycle ops: 1 cycle.
  - MUL: 32 cycles.
  - Result is registered into Di.
- WB -> IDLE unconditionally.
  - WE=1 and done=1 for exactly this cycle.
  - zero and illegal are updated.

Op codes:
- 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR.
- 101 SLT: signed, result 32'd1 or 32'd0.
- 110 SRL: opA >> opB[4:0], logical.
- 111 MUL: low 32 bits of the unsigned product.

Arithmetic and write-back rules:
- All arithmetic is modulo 2^32; carry and overflow are discarded.
- Any register 0–7, including 0, is writable.
- rw equal to ra or rb is legal. Operands are already captured in READ, so the write-back does not disturb them.

Boundary conditions:
- start while busy is ignored; no queuing.
- start held high continuously: a new request is accepted on the first IDLE cycle after WB. The back-to-back period is therefore 4 cycles for single-cycle ops.
- cr=1 in any state at an edge:
  - state goes to IDLE;
  - WE, done, busy, illegal and zero go to 0; Di goes to 0; Addr_A/B/W go to 0;
  - the multiplier counter is cleared;
  - no write occurs in that cycle even if the FSM was in WB.
- Inputs op, ra, rb and rw are don't-care outside the start-accept edge.

## Timing
Let start be sampled high at edge E0:
- READ occupies cycle E0–E1.
- For single-cycle ops, EXEC occupies E1–E2 and WB occupies E2–E3.
  - WE, done and Di are valid during E2–E3.
  - The register file commits the result at edge E3.
- MUL: EXEC lasts 32 cycles, so WE is high during E33–E34.
- Reset values: every output is 0 and the state is IDLE.
- QA/QB are sampled at E1, one full cycle after the registered Addr_A/B change. This allows for the register file's combinational read path.

## Configuration
- Macro: ALU_EXEC_MUL_EN.
- Defined:
  - op 111 performs the 32-cycle shift-add multiply;
  - illegal stays 0 for all ops.
- Undefined:
  - no multiplier hardware is built;
  - op 111 spends 1 EXEC cycle, then WB with WE=0, done=1, illegal=1;
  - Di is forced to 0 and zero is set to 1.

## Structure
- Package alu_exec_pkg holds:
  - op-code localparams (OP_ADD … OP_MUL);
  - the state encoding (S_IDLE, S_READ, S_EXEC, S_WB, 2 bits).
- Sub-module mul_shift_add_32 is instantiated only under ALU_EXEC_MUL_EN.
  - Ports: clk, cr, go, a, b, busy, p[31:0].
  - Internals: 5-bit iteration counter and 32-bit accumulator.
- The single-cycle ALU stays inline in alu_exec_seq as a combinational case on the latched op.

## Test plan
- Reg1=5, Reg2=7; start op=ADD ra=1 rb=2 rw=3 → WE high exactly at cycle 3 after accept, Addr_W=3, Di=12, zero=0; busy high for 3 cycles.
- Reg4=3, Reg5=3; op=SUB ra=4 rb=5 rw=4 (rw aliases ra) → Di=0, zero=1, register 4 ends at 0.
- Reg1=32'hFFFF_FFFF, Reg2=1; op=SLT ra=1 rb=2 → Di=1; op=SRL with Reg2=4 → Di=32'h0FFF_FFFF.
- With ALU_EXEC_MUL_EN: Reg1=32'h0001_0000, Reg2=32'h0001_0003; op=MUL → WE 34 cycles after accept, Di=32'h0003_0000. Without the macro: done at cycle 3, WE=0, illegal=1.
- start pulsed again during EXEC → ignored: exactly one WE pulse and one done pulse.
- cr asserted during WB cycle → no write committed (register unchanged), next cycle all outputs 0, state IDLE; a subsequent start completes normally.
